lcd_spi_receiver: RTL and testbench

- LCD-side end of the 4-wire display SPI link (cs, dc/rs, sdi, sck) driven by the team's LCD SPI controller.
- Oversamples the link on the system clock and deserialises MSB-first bytes with their dc flag.
- Decodes the ILI9341 command subset the controller uses and emits addressed RGB565 pixel writes for an on-FPGA framebuffer or scoreboard.
- Used for loopback self-test, and as the display emulator when no panel is fitted.

---
 rtl/lcd_spi_pkg.sv | 27 ++
 rtl/lcd_spi_byte_rx.sv | 73 +++++++
 rtl/lcd_spi_receiver.sv | 175 +++++++++++++++++
 tb/tb_lcd_spi_receiver.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// Shared opcodes, decoder state encoding and reset defaults for the LCD SPI receiver.
package lcd_spi_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    localparam logic [7:0] COLMOD_RST  = 8'h66;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_PASET,
        S_COLMOD,
        S_RAMWR_HI,
        S_RAMWR_LO,
        S_SKIP
    } dec_state_e;

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Oversampling SPI mode-0 byte deserialiser: synchronisers, sck edge detect,
// MSB-first shifter and partial-byte error on cs release.
module lcd_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cs_i,
    input  logic       dcrs_i,
    input  logic       sdi_i,
    input  logic       sck_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       byte_dc_o,
    output logic       err_o
);

    // Packed as {cs, dcrs, sdi, sck}; cs idles high, sck idles low.
    localparam logic [3:0] SYNC_RST = 4'b1000;

    logic [3:0] sync_q [SYNC_STAGES];
    logic       sck_prev_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic [7:0] byte_q;
    logic       dc_q;
    logic       valid_q;
    logic       err_q;

    logic cs_s, dcrs_s, sdi_s, sck_s, sck_rise;

    assign {cs_s, dcrs_s, sdi_s, sck_s} = sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the synchroniser array is plain flops, not RAM, so every stage takes the async reset.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            sck_prev_q <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            dc_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere, so each read below sees the value from before this edge.
            sync_q[0] <= {cs_i, dcrs_i, sdi_i, sck_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sck_prev_q <= sck_s;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            if (cs_s) begin
                cnt_q <= '0;
                if (cnt_q != 3'd0) err_q <= 1'b1;
            end else if (sck_rise) begin
                shift_q <= {shift_q[5:0], sdi_s};
                cnt_q   <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    byte_q  <= {shift_q, sdi_s};
                    dc_q    <= dcrs_s;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = byte_q;
    assign byte_dc_o    = dc_q;
    assign err_o        = err_q;

endmodule

// File: rtl/lcd_spi_receiver.sv
// ILI9341-subset display emulator: decodes received command/parameter bytes
// into window, status and addressed RGB565 pixel writes.
module lcd_spi_receiver
    import lcd_spi_pkg::*;
#(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      i_clk_100MHz,
    input  logic                      i_rst_n,
    input  logic                      i_cs,
    input  logic                      i_dcrs,
    input  logic                      i_sdi,
    input  logic                      i_sck,
    output logic                      o_byte_valid,
    output logic [7:0]                o_byte,
    output logic                      o_byte_dc,
    output logic                      o_pix_valid,
    output logic [15:0]               o_pix_data,
    output logic [$clog2(WIDTH)-1:0]  o_pix_x,
    output logic [$clog2(HEIGHT)-1:0] o_pix_y,
    output logic                      o_display_on,
    output logic                      o_sleep,
    output logic [7:0]                o_colmod,
    output logic                      o_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef struct packed {
        dec_state_e       state;
        logic [1:0]       pcnt;
        logic [23:0]      pbuf;
        logic [7:0]       hi;
        logic [XW-1:0]    sc, ec, x;
        logic [YW-1:0]    sp, ep, y;
        logic             display_on;
        logic             sleep;
        logic [7:0]       colmod;
        logic             pix_valid;
        logic [15:0]      pix_data;
        logic [XW-1:0]    pix_x;
        logic [YW-1:0]    pix_y;
        logic             err;
    } dec_t;

    // Shared by the async reset and the 0x01 software reset.
    function automatic dec_t dec_reset();
        dec_t r;
        r        = '0;
        r.state  = S_IDLE;
        r.ec     = XW'(WIDTH - 1);
        r.ep     = YW'(HEIGHT - 1);
        r.sleep  = 1'b1;
        r.colmod = COLMOD_RST;
        return r;
    endfunction

    logic       rx_valid, rx_dc, rx_err;
    logic [7:0] rx_byte;

    lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk_i        (i_clk_100MHz),
        .rst_ni       (i_rst_n),
        .cs_i         (i_cs),
        .dcrs_i       (i_dcrs),
        .sdi_i        (i_sdi),
        .sck_i        (i_sck),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .byte_dc_o    (rx_dc),
        .err_o        (rx_err)
    );

    dec_t        dec_q;
    logic [15:0] win_start, win_end, win_lim;
    logic        win_bad;

    always_comb begin
        // NOTE: every output gets a value before any condition, so no latch can be inferred.
        win_start = dec_q.pbuf[23:8];
        win_end   = {dec_q.pbuf[7:0], rx_byte};
        win_lim   = (dec_q.state == S_CASET) ? 16'(WIDTH) : 16'(HEIGHT);
        win_bad   = (win_start > win_end) || (win_end >= win_lim);
    end

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dec_q <= dec_reset();
        end else begin
            dec_q.pix_valid <= 1'b0;
            dec_q.err       <= 1'b0;
            if (rx_valid && !rx_dc) begin
                dec_q.pcnt <= '0;
                case (rx_byte)
                    CMD_CASET:   dec_q.state <= S_CASET;
                    CMD_PASET:   dec_q.state <= S_PASET;
                    CMD_COLMOD:  dec_q.state <= S_COLMOD;
                    CMD_RAMWR: begin
                        dec_q.x     <= dec_q.sc;
                        dec_q.y     <= dec_q.sp;
                        dec_q.state <= S_RAMWR_HI;
                    end
                    CMD_RAMWRC:  dec_q.state <= S_RAMWR_HI;
                    CMD_DISPOFF: begin dec_q.display_on <= 1'b0; dec_q.state <= S_IDLE; end
                    CMD_DISPON:  begin dec_q.display_on <= 1'b1; dec_q.state <= S_IDLE; end
                    CMD_SLPIN:   begin dec_q.sleep      <= 1'b1; dec_q.state <= S_IDLE; end
                    CMD_SLPOUT:  begin dec_q.sleep      <= 1'b0; dec_q.state <= S_IDLE; end
                    CMD_SWRESET: dec_q <= dec_reset();
                    default:     dec_q.state <= S_SKIP;
                endcase
            end else if (rx_valid) begin
                case (dec_q.state)
                    S_CASET, S_PASET: begin
                        if (dec_q.pcnt == 2'd3) begin
                            dec_q.state <= S_IDLE;
                            if (win_bad) begin
                                dec_q.err <= 1'b1;
                            end else if (dec_q.state == S_CASET) begin
                                dec_q.sc <= win_start[XW-1:0];
                                dec_q.ec <= win_end[XW-1:0];
                            end else begin
                                dec_q.sp <= win_start[YW-1:0];
                                dec_q.ep <= win_end[YW-1:0];
                            end
                        end else begin
                            dec_q.pbuf <= {dec_q.pbuf[15:0], rx_byte};
                            dec_q.pcnt <= dec_q.pcnt + 2'd1;
                        end
                    end
                    S_COLMOD: begin
                        if (dec_q.pcnt == 2'd0) begin
                            dec_q.colmod <= rx_byte;
                            dec_q.pcnt   <= 2'd1;
                        end
                    end
                    S_RAMWR_HI: begin
                        dec_q.hi    <= rx_byte;
                        dec_q.state <= S_RAMWR_LO;
                    end
                    S_RAMWR_LO: begin
                        dec_q.pix_valid <= 1'b1;
                        dec_q.pix_data  <= {dec_q.hi, rx_byte};
                        dec_q.pix_x     <= dec_q.x;
                        dec_q.pix_y     <= dec_q.y;
                        dec_q.state     <= S_RAMWR_HI;
                        // Row-major scan with wrap back to the window origin.
                        if (dec_q.x == dec_q.ec) begin
                            dec_q.x <= dec_q.sc;
                            dec_q.y <= (dec_q.y == dec_q.ep) ? dec_q.sp : dec_q.y + YW'(1);
                        end else begin
                            dec_q.x <= dec_q.x + XW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_byte_valid = rx_valid;
    assign o_byte       = rx_byte;
    assign o_byte_dc    = rx_dc;
    assign o_pix_valid  = dec_q.pix_valid;
    assign o_pix_data   = dec_q.pix_data;
    assign o_pix_x      = dec_q.pix_x;
    assign o_pix_y      = dec_q.pix_y;
    assign o_display_on = dec_q.display_on;
    assign o_sleep      = dec_q.sleep;
    assign o_colmod     = dec_q.colmod;
    assign o_err        = rx_err | dec_q.err;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Scoreboard bench: stimulus feeds a transaction-level display model, a monitor
// pops expected bytes, pixels and error pulses as the DUT presents them.
module tb_lcd_spi_receiver;
    import lcd_spi_pkg::*;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 320;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);

    logic clk = 1'b0, rst_n = 1'b0;
    logic cs = 1'b1, dcrs = 1'b0, sdi = 1'b0, sck = 1'b0;
    logic          o_byte_valid, o_byte_dc, o_pix_valid, o_display_on, o_sleep, o_err;
    logic [7:0]    o_byte, o_colmod;
    logic [15:0]   o_pix_data;
    logic [XW-1:0] o_pix_x;
    logic [YW-1:0] o_pix_y;

    always #5 clk = ~clk;

    lcd_spi_receiver #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SYNC_STAGES(2)) dut (
        .i_clk_100MHz (clk),
        .i_rst_n      (rst_n),
        .i_cs         (cs),
        .i_dcrs       (dcrs),
        .i_sdi        (sdi),
        .i_sck        (sck),
        .o_byte_valid (o_byte_valid),
        .o_byte       (o_byte),
        .o_byte_dc    (o_byte_dc),
        .o_pix_valid  (o_pix_valid),
        .o_pix_data   (o_pix_data),
        .o_pix_x      (o_pix_x),
        .o_pix_y      (o_pix_y),
        .o_display_on (o_display_on),
        .o_sleep      (o_sleep),
        .o_colmod     (o_colmod),
        .o_err        (o_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Scoreboard queues
    typedef struct { int x; int y; int d; } pix_t;
    logic [8:0] exp_byte_q[$];
    pix_t       exp_pix_q[$];
    int         exp_err = 0;

    // Display model: windows, cursor and status as plain integers
    int  m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_cmd;
    bit  m_on, m_sleep;
    int  m_colmod;
    int  m_params[$];

    function automatic void model_reset();
        m_sc = 0; m_ec = WIDTH - 1; m_sp = 0; m_ep = HEIGHT - 1;
        m_x = 0; m_y = 0; m_cmd = -1;
        m_on = 1'b0; m_sleep = 1'b1; m_colmod = 'h66;
        m_params = {};
    endfunction

    function automatic void model_byte(input bit dc, input logic [7:0] b);
        int s, e, lim;
        exp_byte_q.push_back({dc, b});
        if (!dc) begin
            m_params = {};
            m_cmd = int'(b);
            case (m_cmd)
                'h2C: begin m_x = m_sc; m_y = m_sp; end
                'h28: m_on = 1'b0;
                'h29: m_on = 1'b1;
                'h10: m_sleep = 1'b1;
                'h11: m_sleep = 1'b0;
                'h01: model_reset();
                default: ;
            endcase
        end else begin
            case (m_cmd)
                'h2A, 'h2B: begin
                    m_params.push_back(int'(b));
                    if (m_params.size() == 4) begin
                        s   = m_params[0] * 256 + m_params[1];
                        e   = m_params[2] * 256 + m_params[3];
                        lim = (m_cmd == 'h2A) ? WIDTH : HEIGHT;
                        if (s > e || e >= lim) exp_err++;
                        else if (m_cmd == 'h2A) begin m_sc = s; m_ec = e; end
                        else begin m_sp = s; m_ep = e; end
                        m_cmd = -1;
                    end
                end
                'h3A: begin
                    if (m_params.size() == 0) m_colmod = int'(b);
                    m_params.push_back(int'(b));
                end
                'h2C, 'h3C: begin
                    m_params.push_back(int'(b));
                    if (m_params.size() == 2) begin
                        exp_pix_q.push_back('{m_x, m_y, m_params[0] * 256 + m_params[1]});
                        m_params = {};
                        if (m_x == m_ec) begin
                            m_x = m_sc;
                            m_y = (m_y == m_ep) ? m_sp : m_y + 1;
                        end else begin
                            m_x = m_x + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // Monitor: compares whatever the DUT presents against the queues
    logic [8:0] mon_b;
    pix_t       mon_p;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (o_byte_valid) begin
                    if (exp_byte_q.size() == 0) check("byte_unexpected", 1, 0);
                    else begin
                        mon_b = exp_byte_q.pop_front();
                        check("byte", {o_byte_dc, o_byte}, mon_b);
                    end
                end
                if (o_pix_valid) begin
                    if (exp_pix_q.size() == 0) check("pix_unexpected", 1, 0);
                    else begin
                        mon_p = exp_pix_q.pop_front();
                        check("pix_x", o_pix_x, mon_p.x);
                        check("pix_y", o_pix_y, mon_p.y);
                        check("pix_data", o_pix_data, mon_p.d);
                    end
                end
                if (o_err) begin
                    check("err_pulse", o_err, (exp_err > 0) ? 1 : 0);
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    bit tog_cs = 1'b0;
    bit win_dirty = 1'b0;

    task automatic cs_low();
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input bit dc, input logic [7:0] b);
        model_byte(dc, b);
        if (cs) cs_low();
        dcrs = dc;
        for (int i = 7; i >= 0; i--) begin
            sdi = b[i]; sck = 1'b0; repeat (3) @(negedge clk);
            sck = 1'b1; repeat (3) @(negedge clk);
        end
        sck = 1'b0;
        repeat (3) @(negedge clk);
        if (tog_cs) cs_high();
    endtask

    task automatic partial(input int n);
        if (cs) cs_low();
        for (int i = 0; i < n; i++) begin
            sdi = 1'($urandom); sck = 1'b0; repeat (3) @(negedge clk);
            sck = 1'b1; repeat (3) @(negedge clk);
        end
        sck = 1'b0;
        repeat (3) @(negedge clk);
        if (n > 0) exp_err++;
        cs_high();
    endtask

    task automatic check_status(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_display_on"}, o_display_on, m_on);
        check({tag, "_sleep"}, o_sleep, m_sleep);
        check({tag, "_colmod"}, o_colmod, m_colmod);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_valid"}, o_byte_valid, 0);
        check({tag, "_byte"}, o_byte, 0);
        check({tag, "_byte_dc"}, o_byte_dc, 0);
        check({tag, "_pix_valid"}, o_pix_valid, 0);
        check({tag, "_pix_data"}, o_pix_data, 0);
        check({tag, "_pix_x"}, o_pix_x, 0);
        check({tag, "_pix_y"}, o_pix_y, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_display_on"}, o_display_on, 0);
        check({tag, "_sleep"}, o_sleep, 1);
        check({tag, "_colmod"}, o_colmod, 'h66);
    endtask

    task automatic hw_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; sdi = 1'b0; dcrs = 1'b0;
        @(negedge clk);
        model_reset();
        check_reset_outputs("hw_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_seq(input bit dc, input logic [31:0] bytes, input int n);
        logic [31:0] v;
        v = bytes;
        for (int i = n - 1; i >= 0; i--) send(dc, v[i*8 +: 8]);
    endtask

    task automatic rand_window(input bit is_col);
        int lim, s, e, n;
        logic [15:0] sv, ev;
        logic [31:0] pk;
        lim = is_col ? WIDTH : HEIGHT;
        s = int'($urandom_range(0, lim - 1));
        if ($urandom_range(0, 1) == 1) e = int'($urandom_range(s, lim - 1));
        else e = (s + 3 < lim) ? s + int'($urandom_range(0, 3)) : lim - 1;
        case ($urandom_range(0, 7))
            0: e = lim + int'($urandom_range(0, 100));
            1: if (s > 0) e = int'($urandom_range(0, s - 1));
            default: ;
        endcase
        sv = 16'(s);
        ev = 16'(e);
        pk = {sv, ev};
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
        send(1'b0, is_col ? CMD_CASET : CMD_PASET);
        for (int i = 0; i < n; i++) send(1'b1, pk[(3 - i)*8 +: 8]);
        win_dirty = 1'b1;
    endtask

    task automatic rand_pixels();
        int n;
        n = 2 * int'($urandom_range(1, 6)) + int'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) send(1'b1, 8'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_rst");

        // Sleep out, display on
        send(1'b0, CMD_SLPOUT);
        check_status("slpout");
        send(1'b0, CMD_DISPON);
        check_status("dispon");

        // Partial byte, then a whole byte
        send(1'b0, CMD_DISPOFF);
        partial(5);
        send(1'b0, CMD_DISPON);
        check_status("partial");

        // Rejected column window keeps the full-screen window
        send(1'b0, CMD_CASET);
        send_seq(1'b1, 32'h0005_0002, 4);
        send(1'b0, CMD_RAMWR);
        send_seq(1'b1, 32'h0000_ABCD, 2);

        // 2x2 window, wrap back to origin
        send(1'b0, CMD_CASET);
        send_seq(1'b1, 32'h000A_000B, 4);
        send(1'b0, CMD_PASET);
        send_seq(1'b1, 32'h0014_0015, 4);
        send(1'b0, CMD_RAMWR);
        send_seq(1'b1, 32'hF800_07E0, 4);
        send_seq(1'b1, 32'h001F_FFFF, 4);
        send_seq(1'b1, 32'h0000_1234, 2);

        // cs toggled per byte, reset between high and low byte
        tog_cs = 1'b1;
        send(1'b0, CMD_RAMWR);
        send_seq(1'b1, 32'h1111_2222, 4);
        send(1'b1, 8'h33);
        repeat (6) @(negedge clk);
        check("pre_reset_pix_drained", exp_pix_q.size(), 0);
        hw_reset();
        send_seq(1'b1, 32'h0000_4455, 2);
        send(1'b0, CMD_RAMWR);
        send_seq(1'b1, 32'h0000_6677, 2);
        tog_cs = 1'b0;
        win_dirty = 1'b0;

        // Randomised command mix
        for (int op = 0; op < 80; op++) begin
            tog_cs = 1'($urandom);
            case ($urandom_range(0, 9))
                0: rand_window(1'b1);
                1: rand_window(1'b0);
                2, 3: begin
                    send(1'b0, CMD_RAMWR);
                    win_dirty = 1'b0;
                    rand_pixels();
                end
                4: begin
                    send(1'b0, win_dirty ? CMD_RAMWR : CMD_RAMWRC);
                    win_dirty = 1'b0;
                    rand_pixels();
                end
                5: begin
                    case ($urandom_range(0, 3))
                        0: send(1'b0, CMD_DISPOFF);
                        1: send(1'b0, CMD_DISPON);
                        2: send(1'b0, CMD_SLPIN);
                        default: send(1'b0, CMD_SLPOUT);
                    endcase
                end
                6: begin
                    send(1'b0, CMD_COLMOD);
                    for (int i = 0; i < int'($urandom_range(0, 2)); i++) send(1'b1, 8'($urandom));
                end
                7: begin
                    case ($urandom_range(0, 3))
                        0: send(1'b0, 8'h00);
                        1: send(1'b0, 8'h36);
                        2: send(1'b0, 8'hB1);
                        default: send(1'b0, 8'hD3);
                    endcase
                    for (int i = 0; i < int'($urandom_range(0, 3)); i++) send(1'b1, 8'($urandom));
                end
                8: partial(int'($urandom_range(1, 7)));
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        send(1'b0, CMD_SWRESET);
                        win_dirty = 1'b0;
                    end else begin
                        send(1'b0, CMD_RAMWR);
                        win_dirty = 1'b0;
                        rand_pixels();
                    end
                end
            endcase
            check_status("rand");
        end

        if (cs == 1'b0) cs_high();
        repeat (10) @(negedge clk);
        check("bytes_left", exp_byte_q.size(), 0);
        check("pixels_left", exp_pix_q.size(), 0);
        check("errs_left", exp_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
